// File: rtl/dlx_mem_pkg.sv
// Shared definitions for the DLX memory-port arbitration logic:
// default bus widths, arbiter state encoding and owner codes.
package dlx_mem_pkg;

    localparam int AW_DEFAULT = 32;
    localparam int DW_DEFAULT = 32;

    typedef enum logic {
        ARB   = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam logic [1:0] OWNER_IDLE = 2'b00;
    localparam logic [1:0] OWNER_R0   = 2'b01;
    localparam logic [1:0] OWNER_R1   = 2'b10;

endpackage

// File: rtl/ram_arb_sat_counter.sv
// Saturating up-counter used by the arbiter for its wait and burst counts.
// A clear takes priority over an increment; the count never wraps past MAX.
module ram_arb_sat_counter #(
    parameter int WIDTH = 3,
    parameter int MAX   = 4
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             sat
);

    assign sat = (count == WIDTH'(MAX));

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !sat) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the single RAM port between the pipeline data port (r0, priority)
// and the loader/debug port (r1, with starvation guard and locked bursts).
module ram_port_arbiter
    import dlx_mem_pkg::*;
#(
    parameter int AW        = AW_DEFAULT,
    parameter int DW        = DW_DEFAULT,
    parameter int MAX_WAIT  = 4,
    parameter int MAX_BURST = 16
) (
    input  logic          clock_i,
    input  logic          reset_i,
    input  logic          r0_req_i,
    input  logic          r0_we_i,
    input  logic [AW-1:0] r0_adr_i,
    input  logic [DW-1:0] r0_data_i,
    output logic          r0_gnt_o,
    output logic          r0_rvalid_o,
    output logic [DW-1:0] r0_data_o,
    input  logic          r1_req_i,
    input  logic          r1_we_i,
    input  logic [AW-1:0] r1_adr_i,
    input  logic [DW-1:0] r1_data_i,
    output logic          r1_gnt_o,
    output logic          r1_rvalid_o,
    output logic [DW-1:0] r1_data_o,
    input  logic          r1_lock_i,
    output logic [AW-1:0] ram_adr_o,
    output logic          ram_we_o,
    output logic [DW-1:0] ram_data_o,
    input  logic [DW-1:0] ram_data_i,
    output logic [1:0]    owner_o,
    output logic          starve_o
);

    localparam int WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam int BURST_W  = $clog2(MAX_BURST + 1);
    localparam bit BURST_EN = (MAX_BURST > 1);

    arb_state_e         state, next_state;
    logic               r0_gnt, r1_gnt, forced_win;
    logic [WAIT_W-1:0]  wait_cnt;
    logic               wait_sat;
    logic [BURST_W-1:0] burst_cnt;
    logic               burst_sat, burst_last;
    logic               r0_rvalid_q, r1_rvalid_q, starve_q;
    logic [DW-1:0]      r0_data_q, r1_data_q;

    assign burst_last = (burst_cnt == BURST_W'(MAX_BURST - 1));

    ram_arb_sat_counter #(.WIDTH(WAIT_W), .MAX(MAX_WAIT)) u_wait_cnt (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .inc     (r0_gnt && r1_req_i),
        .clr     ((state == BURST) || r1_gnt || !r1_req_i),
        .count   (wait_cnt),
        .sat     (wait_sat)
    );

    ram_arb_sat_counter #(.WIDTH(BURST_W), .MAX(MAX_BURST)) u_burst_cnt (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .inc     (r1_gnt),
        .clr     (next_state == ARB),
        .count   (burst_cnt),
        .sat     (burst_sat)
    );

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state <= ARB;
        end else begin
            state <= next_state;
        end
    end

    // Grants are combinational and suppressed entirely while reset is held.
    // A locked burst that loses its lock or request spends that cycle idle.
    always_comb begin
        r0_gnt     = 1'b0;
        r1_gnt     = 1'b0;
        forced_win = 1'b0;
        next_state = state;
        if (reset_i) begin
            unique case (state)
                ARB: begin
                    if (r0_req_i && r1_req_i) begin
                        if (wait_cnt < WAIT_W'(MAX_WAIT)) begin
                            r0_gnt = 1'b1;
                        end else begin
                            r1_gnt     = 1'b1;
                            forced_win = wait_sat;
                        end
                    end else if (r0_req_i) begin
                        r0_gnt = 1'b1;
                    end else if (r1_req_i) begin
                        r1_gnt = 1'b1;
                    end
                    if (r1_gnt && r1_lock_i && BURST_EN) begin
                        next_state = BURST;
                    end
                end
                BURST: begin
                    if (r1_req_i && r1_lock_i) begin
                        r1_gnt = 1'b1;
                        if (burst_last || burst_sat) begin
                            next_state = ARB;
                        end
                    end else begin
                        next_state = ARB;
                    end
                end
                default: next_state = ARB;
            endcase
        end
    end

    always_comb begin
        ram_adr_o  = '0;
        ram_we_o   = 1'b0;
        ram_data_o = '0;
        owner_o    = OWNER_IDLE;
        if (r0_gnt) begin
            ram_adr_o  = r0_adr_i;
            ram_we_o   = r0_we_i;
            ram_data_o = r0_data_i;
            owner_o    = OWNER_R0;
        end else if (r1_gnt) begin
            ram_adr_o  = r1_adr_i;
            ram_we_o   = r1_we_i;
            ram_data_o = r1_data_i;
            owner_o    = OWNER_R1;
        end
    end

    // Read data is captured from the async RAM output in the grant cycle.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            r0_rvalid_q <= 1'b0;
            r1_rvalid_q <= 1'b0;
            r0_data_q   <= '0;
            r1_data_q   <= '0;
            starve_q    <= 1'b0;
        end else begin
            r0_rvalid_q <= r0_gnt && !r0_we_i;
            r1_rvalid_q <= r1_gnt && !r1_we_i;
            starve_q    <= forced_win;
            if (r0_gnt && !r0_we_i) begin
                r0_data_q <= ram_data_i;
            end
            if (r1_gnt && !r1_we_i) begin
                r1_data_q <= ram_data_i;
            end
        end
    end

    assign r0_gnt_o    = r0_gnt;
    assign r1_gnt_o    = r1_gnt;
    assign r0_rvalid_o = r0_rvalid_q;
    assign r1_rvalid_o = r1_rvalid_q;
    assign r0_data_o   = r0_data_q;
    assign r1_data_o   = r1_data_q;
    assign starve_o    = starve_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter with a small behavioural RAM:
// a directed vector table plus hand-written contention/burst/reset sequences.
module tb_ram_port_arbiter;

    localparam logic [1:0] O_IDLE = 2'b00;
    localparam logic [1:0] O_R0   = 2'b01;
    localparam logic [1:0] O_R1   = 2'b10;

    logic        clock_i = 1'b0;
    logic        reset_i;
    logic        r0_req_i, r0_we_i, r1_req_i, r1_we_i, r1_lock_i;
    logic [31:0] r0_adr_i, r0_data_i, r1_adr_i, r1_data_i;
    logic        r0_gnt_o, r0_rvalid_o, r1_gnt_o, r1_rvalid_o;
    logic [31:0] r0_data_o, r1_data_o;
    logic [31:0] ram_adr_o, ram_data_o, ram_data_i;
    logic        ram_we_o;
    logic [1:0]  owner_o;
    logic        starve_o;

    int tests = 0;
    int fails = 0;

    logic [31:0] mem [0:255];

    typedef struct {
        logic        q0, w0;
        logic [31:0] a0, d0;
        logic        q1, w1;
        logic [31:0] a1, d1;
        logic [1:0]  own;
        logic        we;
        logic [31:0] adr, wd;
        logic        rv0, rv1;
        logic [31:0] e0, e1;
    } vec_t;

    vec_t vecs [12];

    always #5 clock_i = ~clock_i;

    assign ram_data_i = mem[ram_adr_o[7:0]];

    always @(posedge clock_i) begin
        if (ram_we_o) begin
            mem[ram_adr_o[7:0]] <= ram_data_o;
        end
    end

    ram_port_arbiter dut (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .r0_req_i    (r0_req_i),
        .r0_we_i     (r0_we_i),
        .r0_adr_i    (r0_adr_i),
        .r0_data_i   (r0_data_i),
        .r0_gnt_o    (r0_gnt_o),
        .r0_rvalid_o (r0_rvalid_o),
        .r0_data_o   (r0_data_o),
        .r1_req_i    (r1_req_i),
        .r1_we_i     (r1_we_i),
        .r1_adr_i    (r1_adr_i),
        .r1_data_i   (r1_data_i),
        .r1_gnt_o    (r1_gnt_o),
        .r1_rvalid_o (r1_rvalid_o),
        .r1_data_o   (r1_data_o),
        .r1_lock_i   (r1_lock_i),
        .ram_adr_o   (ram_adr_o),
        .ram_we_o    (ram_we_o),
        .ram_data_o  (ram_data_o),
        .ram_data_i  (ram_data_i),
        .owner_o     (owner_o),
        .starve_o    (starve_o)
    );

    function automatic vec_t mk(input logic q0, w0, input logic [31:0] a0, d0,
                                input logic q1, w1, input logic [31:0] a1, d1,
                                input logic [1:0] own, input logic we,
                                input logic [31:0] adr, wd,
                                input logic rv0, rv1, input logic [31:0] e0, e1);
        vec_t v;
        v.q0 = q0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.q1 = q1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.own = own; v.we = we; v.adr = adr; v.wd = wd;
        v.rv0 = rv0; v.rv1 = rv1; v.e0 = e0; v.e1 = e1;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic q0, w0, input logic [31:0] a0, d0,
                         input logic q1, w1, input logic [31:0] a1, d1, input logic lock);
        r0_req_i = q0; r0_we_i = w0; r0_adr_i = a0; r0_data_i = d0;
        r1_req_i = q1; r1_we_i = w1; r1_adr_i = a1; r1_data_i = d1;
        r1_lock_i = lock;
    endtask

    task automatic apply_stimulus(input vec_t v);
        drive(v.q0, v.w0, v.a0, v.d0, v.q1, v.w1, v.a1, v.d1, 1'b0);
    endtask

    // Compares at the falling edge, then moves to just after the next rising edge.
    task automatic check_output(input vec_t v, input int idx);
        @(negedge clock_i);
        check($sformatf("v%0d owner", idx), 32'(owner_o), 32'(v.own));
        check($sformatf("v%0d r0_gnt", idx), 32'(r0_gnt_o), 32'(v.own == O_R0));
        check($sformatf("v%0d r1_gnt", idx), 32'(r1_gnt_o), 32'(v.own == O_R1));
        check($sformatf("v%0d ram_we", idx), 32'(ram_we_o), 32'(v.we));
        check($sformatf("v%0d ram_adr", idx), ram_adr_o, v.adr);
        check($sformatf("v%0d ram_data", idx), ram_data_o, v.wd);
        check($sformatf("v%0d r0_rvalid", idx), 32'(r0_rvalid_o), 32'(v.rv0));
        check($sformatf("v%0d r1_rvalid", idx), 32'(r1_rvalid_o), 32'(v.rv1));
        check($sformatf("v%0d r0_data", idx), r0_data_o, v.e0);
        check($sformatf("v%0d r1_data", idx), r1_data_o, v.e1);
        @(posedge clock_i);
        #1;
    endtask

    task automatic check_cycle(input string tag, input logic [1:0] own, input logic stv);
        @(negedge clock_i);
        check({tag, " owner"}, 32'(owner_o), 32'(own));
        check({tag, " r0_gnt"}, 32'(r0_gnt_o), 32'(own == O_R0));
        check({tag, " r1_gnt"}, 32'(r1_gnt_o), 32'(own == O_R1));
        check({tag, " starve"}, 32'(starve_o), 32'(stv));
        check({tag, " rvalid_excl"}, 32'(r0_rvalid_o && r1_rvalid_o), 32'd0);
        @(posedge clock_i);
        #1;
    endtask

    initial begin
        int r1_grants;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 32'hA5A5_0000 | 32'(i);
        end

        vecs[0]  = mk(1,1,32'h10,32'hDEADBEEF, 0,0,0,0, O_R0,1,32'h10,32'hDEADBEEF, 0,0,0,0);
        vecs[1]  = mk(1,0,32'h10,0, 0,0,0,0, O_R0,0,32'h10,0, 0,0,0,0);
        vecs[2]  = mk(0,0,0,0, 0,0,0,0, O_IDLE,0,0,0, 1,0,32'hDEADBEEF,0);
        vecs[3]  = mk(0,0,0,0, 1,1,32'h24,32'h12345678, O_R1,1,32'h24,32'h12345678, 0,0,32'hDEADBEEF,0);
        vecs[4]  = mk(1,0,32'h20,0, 0,0,0,0, O_R0,0,32'h20,0, 0,0,32'hDEADBEEF,0);
        vecs[5]  = mk(0,0,0,0, 1,0,32'h24,0, O_R1,0,32'h24,0, 1,0,32'hA5A50020,0);
        vecs[6]  = mk(0,0,0,0, 0,0,0,0, O_IDLE,0,0,0, 0,1,32'hA5A50020,32'h12345678);
        vecs[7]  = mk(1,1,32'h30,32'h11111111, 1,1,32'h34,32'h22222222, O_R0,1,32'h30,32'h11111111, 0,0,32'hA5A50020,32'h12345678);
        vecs[8]  = mk(0,0,0,0, 0,0,0,0, O_IDLE,0,0,0, 0,0,32'hA5A50020,32'h12345678);
        vecs[9]  = mk(0,0,0,0, 1,0,32'h34,0, O_R1,0,32'h34,0, 0,0,32'hA5A50020,32'h12345678);
        vecs[10] = mk(1,0,32'h30,0, 0,0,0,0, O_R0,0,32'h30,0, 0,1,32'hA5A50020,32'hA5A50034);
        vecs[11] = mk(0,0,0,0, 0,0,0,0, O_IDLE,0,0,0, 1,0,32'h11111111,32'hA5A50034);

        // Reset held with a pending r0 write: nothing may reach the RAM.
        reset_i = 1'b0;
        drive(1, 1, 32'h10, 32'hBADC0FFE, 0, 0, 0, 0, 0);
        @(negedge clock_i);
        check("rst r0_gnt", 32'(r0_gnt_o), 0);
        check("rst r1_gnt", 32'(r1_gnt_o), 0);
        check("rst ram_we", 32'(ram_we_o), 0);
        check("rst owner", 32'(owner_o), 0);
        check("rst rvalid", 32'({r0_rvalid_o, r1_rvalid_o, starve_o}), 0);
        @(posedge clock_i);
        #1;
        check("rst mem untouched", mem[8'h10], 32'hA5A50010);
        @(posedge clock_i);
        #1;
        reset_i = 1'b1;

        for (int i = 0; i < 12; i++) begin
            apply_stimulus(vecs[i]);
            check_output(vecs[i], i);
        end
        check("mem 0x34 lost write", mem[8'h34], 32'hA5A50034);

        // Continuous contention: r0 x4 then a forced r1 win, starve one cycle later.
        drive(1, 0, 32'h00, 0, 1, 0, 32'h04, 0, 0);
        for (int k = 0; k < 10; k++) begin
            check_cycle($sformatf("cont%0d", k), (k % 5 == 4) ? O_R1 : O_R0,
                        (k % 5 == 0) && (k > 0));
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_cycle("cont_tail", O_IDLE, 1'b1);

        // Locked burst with both requesting: 16 r1 grants, then r0 in ARB.
        drive(1, 0, 32'h00, 0, 1, 0, 32'h04, 0, 1);
        r1_grants = 0;
        for (int k = 0; k < 21; k++) begin
            @(negedge clock_i);
            if (r1_gnt_o) r1_grants++;
            @(posedge clock_i);
            #1;
        end
        check("burst r1 grants", 32'(r1_grants), 32'd16);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_cycle("burst_idle", O_IDLE, 1'b0);
        drive(1, 0, 32'h00, 0, 1, 0, 32'h04, 0, 1);
        for (int k = 0; k < 21; k++) begin
            check_cycle($sformatf("burst%0d", k),
                        (k < 4 || k == 20) ? O_R0 : O_R1, k == 5);
        end

        // Lock dropped after three burst grants.
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_cycle("lock_idle", O_IDLE, 1'b0);
        drive(0, 0, 0, 0, 1, 0, 32'h04, 0, 1);
        check_cycle("lock0", O_R1, 1'b0);
        drive(1, 0, 32'h00, 0, 1, 0, 32'h04, 0, 1);
        check_cycle("lock1", O_R1, 1'b0);
        check_cycle("lock2", O_R1, 1'b0);
        r1_lock_i = 1'b0;
        check_cycle("lock3", O_IDLE, 1'b0);
        check_cycle("lock4", O_R0, 1'b0);

        // Async reset during a locked burst read, before the read data returns.
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_cycle("mid_idle", O_IDLE, 1'b0);
        drive(0, 0, 0, 0, 1, 0, 32'h24, 0, 1);
        @(negedge clock_i);
        check("mid r1_gnt", 32'(r1_gnt_o), 1);
        #2;
        reset_i = 1'b0;
        @(posedge clock_i);
        #1;
        check("mid rst r1_rvalid", 32'(r1_rvalid_o), 0);
        check("mid rst r1_data", r1_data_o, 0);
        check("mid rst r1_gnt", 32'(r1_gnt_o), 0);
        check("mid rst owner", 32'(owner_o), 0);
        reset_i = 1'b1;
        drive(1, 0, 32'h00, 0, 1, 0, 32'h04, 0, 0);
        for (int k = 0; k < 5; k++) begin
            check_cycle($sformatf("post_rst%0d", k), (k == 4) ? O_R1 : O_R0, 1'b0);
            if (k == 0) begin
                check("post_rst r1_rvalid", 32'(r1_rvalid_o), 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
